btb_tagged: RTL and testbench

Parametrised, tagged, direct-mapped branch target buffer for the IF0 stage. It is the successor to the untagged single-counter predictor. Each entry holds a tag, target, branch type, slot position and its own 2-bit saturating direction counter. Lookups are registered (1-cycle latency) and update feedback comes from EX. A reset/flush sweep FSM invalidates all entries one per cycle.

---
 rtl/btb_tagged.sv | 174 +++++++++++++++++
 tb/tb_btb_tagged.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_tagged.sv
// Tagged, direct-mapped branch target buffer with per-entry 2-bit direction counters.
// Registered lookup (1-cycle latency), EX-driven updates, and a one-entry-per-cycle invalidate sweep.
module btb_tagged #(
  parameter int         ENTRIES  = 64,
  parameter int         TAG_W    = 12,
  parameter int         ALIGN    = 3,
  parameter logic [1:0] CNT_INIT = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if0_allowin,
  input  logic        req_valid,
  input  logic [31:0] fetch_pc,
  output logic        ready,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_pc,
  output logic [1:0]  pred_btype,
  output logic        pred_bpos,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_tpc,
  input  logic        upd_taken,
  input  logic [1:0]  upd_btype,
  input  logic        upd_bpos,
  input  logic        flush_all
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int HI_W  = 32 - ALIGN;

  typedef enum logic {ST_SWEEP, ST_RUN} state_t;

  state_t            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_sweep_idx, w_sweep_idx_nxt;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag   [ENTRIES];
  logic [31:0]        r_tgt   [ENTRIES];
  logic [1:0]         r_btype [ENTRIES];
  logic               r_bpos  [ENTRIES];
  logic [1:0]         r_cnt   [ENTRIES];

  function automatic logic [IDX_W-1:0] f_idx(input logic [31:0] pc);
    return pc[ALIGN +: IDX_W];
  endfunction

  function automatic logic [TAG_W-1:0] f_tag(input logic [31:0] pc);
    return pc[ALIGN+IDX_W +: TAG_W];
  endfunction

  function automatic logic [31:0] f_seq(input logic [31:0] pc);
    logic [HI_W-1:0] hi;
    hi = pc[31:ALIGN] + HI_W'(1);
    return {hi, {ALIGN{1'b0}}};
  endfunction

  // Low alignment bits of fetch_pc and the bits of upd_pc outside idx/tag carry no information here.
  logic w_unused;
  assign w_unused = ^{fetch_pc[ALIGN-1:0], upd_pc};

  // ---------------- sweep FSM ----------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_state_nxt     = r_state;
    w_sweep_idx_nxt = r_sweep_idx;
    if (flush_all) begin
      w_state_nxt     = ST_SWEEP;
      w_sweep_idx_nxt = '0;
    end else if (r_state == ST_SWEEP) begin
      w_sweep_idx_nxt = r_sweep_idx + IDX_W'(1);
      if (r_sweep_idx == IDX_W'(ENTRIES - 1)) w_state_nxt = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      r_state     <= ST_SWEEP;
      r_sweep_idx <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep_idx <= w_sweep_idx_nxt;
    end
  end

  assign ready = (r_state == ST_RUN);

  // ---------------- lookup ----------------
  logic [IDX_W-1:0] w_l_idx;
  logic [TAG_W-1:0] w_l_tag;
  logic [31:0]      w_l_seq;
  logic             w_l_hit;
  logic [1:0]       w_l_btype;
  logic             w_l_taken;

  assign w_l_idx   = f_idx(fetch_pc);
  assign w_l_tag   = f_tag(fetch_pc);
  assign w_l_seq   = f_seq(fetch_pc);
  assign w_l_hit   = ready && req_valid && r_valid[w_l_idx] && (r_tag[w_l_idx] == w_l_tag);
  assign w_l_btype = r_btype[w_l_idx];
  // Unconditional and indirect branches are always taken; conditionals follow the counter MSB.
  assign w_l_taken = (w_l_btype == 2'b01) || (w_l_btype == 2'b11) || r_cnt[w_l_idx][1];

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_hit   <= 1'b0;
      pred_taken <= 1'b0;
      pred_pc    <= 32'h0;
      pred_btype <= 2'b00;
      pred_bpos  <= 1'b0;
    end else if (if0_allowin) begin
      if (w_l_hit) begin
        pred_hit   <= 1'b1;
        pred_taken <= w_l_taken;
        pred_pc    <= w_l_taken ? r_tgt[w_l_idx] : w_l_seq;
        pred_btype <= w_l_btype;
        pred_bpos  <= r_bpos[w_l_idx];
      end else begin
        pred_hit   <= 1'b0;
        pred_taken <= 1'b0;
        pred_pc    <= w_l_seq;
        pred_btype <= 2'b00;
        pred_bpos  <= 1'b0;
      end
    end
  end

  // ---------------- update / sweep write port ----------------
  logic [IDX_W-1:0] w_u_idx;
  logic             w_u_en;
  logic             w_u_hit;
  logic [1:0]       w_u_cnt_nxt;
  logic             w_sweep_clr;

  assign w_u_idx     = f_idx(upd_pc);
  assign w_u_en      = ready && upd_valid && !flush_all && !rst;
  assign w_u_hit     = r_valid[w_u_idx] && (r_tag[w_u_idx] == f_tag(upd_pc));
  assign w_sweep_clr = (r_state == ST_SWEEP) && !rst && !flush_all;

  always_comb begin
    w_u_cnt_nxt = r_cnt[w_u_idx];
    if (upd_taken && r_cnt[w_u_idx] != 2'b11) w_u_cnt_nxt = r_cnt[w_u_idx] + 2'b01;
    else if (!upd_taken && r_cnt[w_u_idx] != 2'b00) w_u_cnt_nxt = r_cnt[w_u_idx] - 2'b01;
  end

  // NOTE: the entry array has no reset; only valid bits matter and the sweep clears them before RUN.
  always_ff @(posedge clk) begin
    if (w_sweep_clr) begin
      r_valid[r_sweep_idx] <= 1'b0;
    end else if (w_u_en) begin
      if (w_u_hit) begin
        if (upd_btype == 2'b00) begin
          r_valid[w_u_idx] <= 1'b0;
        end else begin
          r_cnt[w_u_idx] <= w_u_cnt_nxt;
          if (upd_taken) begin
            r_tgt[w_u_idx]   <= upd_tpc;
            r_btype[w_u_idx] <= upd_btype;
            r_bpos[w_u_idx]  <= upd_bpos;
          end
        end
      end else if (upd_taken && upd_btype != 2'b00) begin
        r_valid[w_u_idx] <= 1'b1;
        r_tag[w_u_idx]   <= f_tag(upd_pc);
        r_tgt[w_u_idx]   <= upd_tpc;
        r_btype[w_u_idx] <= upd_btype;
        r_bpos[w_u_idx]  <= upd_bpos;
        r_cnt[w_u_idx]   <= upd_taken ? CNT_INIT : 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_btb_tagged.sv
// Self-checking bench for btb_tagged: an abstract per-entry model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_btb_tagged;

  localparam int ENTRIES = 64;

  logic        clk = 1'b0;
  logic        rst, if0_allowin, req_valid;
  logic [31:0] fetch_pc;
  logic        ready, pred_hit, pred_taken, pred_bpos;
  logic [31:0] pred_pc;
  logic [1:0]  pred_btype;
  logic        upd_valid, upd_taken, upd_bpos, flush_all;
  logic [31:0] upd_pc, upd_tpc;
  logic [1:0]  upd_btype;

  always #5 clk = ~clk;

  btb_tagged dut (
    .clk(clk), .rst(rst), .if0_allowin(if0_allowin), .req_valid(req_valid),
    .fetch_pc(fetch_pc), .ready(ready), .pred_hit(pred_hit), .pred_taken(pred_taken),
    .pred_pc(pred_pc), .pred_btype(pred_btype), .pred_bpos(pred_bpos),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_tpc(upd_tpc), .upd_taken(upd_taken),
    .upd_btype(upd_btype), .upd_bpos(upd_bpos), .flush_all(flush_all)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid [ENTRIES];
  logic [11:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  logic [1:0]  m_btype [ENTRIES];
  logic        m_bpos  [ENTRIES];
  int          m_cnt   [ENTRIES];
  int          sweep_left = ENTRIES;
  bit          started = 1'b0;
  logic        exp_hit, exp_taken, exp_bpos;
  logic [31:0] exp_pc;
  logic [1:0]  exp_btype;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 3) % ENTRIES);
  endfunction

  function automatic logic [11:0] tag_of(input logic [31:0] pc);
    return 12'((pc >> 9) & 32'hFFF);
  endfunction

  function automatic logic [31:0] seq_of(input logic [31:0] pc);
    return (pc & ~32'h7) + 32'd8;
  endfunction

  always @(posedge clk) begin
    int  li, ui;
    bit  uhit;
    if (rst) begin
      started    = 1'b1;
      sweep_left = ENTRIES;
      exp_hit = 1'b0; exp_taken = 1'b0; exp_pc = 32'h0; exp_btype = 2'b00; exp_bpos = 1'b0;
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    end else begin
      if (if0_allowin) begin
        li = idx_of(fetch_pc);
        if (req_valid && sweep_left == 0 && m_valid[li] && m_tag[li] == tag_of(fetch_pc)) begin
          exp_hit   = 1'b1;
          exp_btype = m_btype[li];
          exp_bpos  = m_bpos[li];
          exp_taken = (m_btype[li] == 2'b01) || (m_btype[li] == 2'b11) || (m_cnt[li] >= 2);
          exp_pc    = exp_taken ? m_tgt[li] : seq_of(fetch_pc);
        end else begin
          exp_hit = 1'b0; exp_taken = 1'b0; exp_pc = seq_of(fetch_pc);
          exp_btype = 2'b00; exp_bpos = 1'b0;
        end
      end
      if (flush_all) begin
        sweep_left = ENTRIES;
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
      end else if (sweep_left > 0) begin
        sweep_left--;
      end else if (upd_valid) begin
        ui   = idx_of(upd_pc);
        uhit = m_valid[ui] && (m_tag[ui] == tag_of(upd_pc));
        if (uhit && upd_btype == 2'b00) begin
          m_valid[ui] = 1'b0;
        end else if (uhit) begin
          m_cnt[ui] = upd_taken ? ((m_cnt[ui] < 3) ? m_cnt[ui] + 1 : 3)
                                : ((m_cnt[ui] > 0) ? m_cnt[ui] - 1 : 0);
          if (upd_taken) begin
            m_tgt[ui] = upd_tpc; m_btype[ui] = upd_btype; m_bpos[ui] = upd_bpos;
          end
        end else if (upd_taken && upd_btype != 2'b00) begin
          m_valid[ui] = 1'b1; m_tag[ui] = tag_of(upd_pc); m_tgt[ui] = upd_tpc;
          m_btype[ui] = upd_btype; m_bpos[ui] = upd_bpos; m_cnt[ui] = 2;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("ready",      32'(ready),      32'(sweep_left == 0));
      check("pred_hit",   32'(pred_hit),   32'(exp_hit));
      check("pred_taken", 32'(pred_taken), 32'(exp_taken));
      check("pred_pc",    pred_pc,         exp_pc);
      check("pred_btype", 32'(pred_btype), 32'(exp_btype));
      check("pred_bpos",  32'(pred_bpos),  32'(exp_bpos));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic do_lookup(input logic [31:0] pc);
    fetch_pc  = pc;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_update(input logic [31:0] pc, input logic [31:0] tpc, input logic taken,
                           input logic [1:0] btype, input logic bpos);
    upd_pc = pc; upd_tpc = tpc; upd_taken = taken; upd_btype = btype; upd_bpos = bpos;
    upd_valid = 1'b1;
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  task automatic expect_resp(input string name, input logic hit, input logic taken,
                             input logic [31:0] pc);
    check({name, "_hit"},   32'(pred_hit),   32'(hit));
    check({name, "_taken"}, 32'(pred_taken), 32'(taken));
    check({name, "_pc"},    pred_pc,         pc);
  endtask

  task automatic count_sweep(output int n);
    n = 0;
    while (!ready && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; if0_allowin = 1'b1; req_valid = 1'b0; fetch_pc = 32'h0;
    upd_valid = 1'b0; upd_pc = 32'h0; upd_tpc = 32'h0; upd_taken = 1'b0;
    upd_btype = 2'b00; upd_bpos = 1'b0; flush_all = 1'b0;
    repeat (2) @(negedge clk);
    expect_resp("reset", 1'b0, 1'b0, 32'h0);
    check("reset_ready", 32'(ready), 32'd0);

    // Initial sweep with a lookup in flight
    rst = 1'b0; fetch_pc = 32'h1C00_0000; req_valid = 1'b1;
    n = 0;
    while (!ready && n < 200) begin
      n++;
      if (n == 2) expect_resp("sweep_lookup", 1'b0, 1'b0, 32'h1C00_0008);
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("init_sweep_len", 32'(n), 32'd64);

    // Allocation and first hit
    do_update(32'h1C00_0100, 32'h1C00_0200, 1'b1, 2'b10, 1'b1);
    do_lookup(32'h1C00_0100);
    expect_resp("alloc", 1'b1, 1'b1, 32'h1C00_0200);
    check("alloc_bpos",  32'(pred_bpos),  32'd1);
    check("alloc_btype", 32'(pred_btype), 32'd2);

    // Counter walk with saturation at both ends
    repeat (2) do_update(32'h1C00_0100, 32'h1C00_0200, 1'b0, 2'b10, 1'b1);
    do_lookup(32'h1C00_0100);
    expect_resp("cnt00", 1'b1, 1'b0, 32'h1C00_0108);
    do_update(32'h1C00_0100, 32'h1C00_0200, 1'b0, 2'b10, 1'b1);
    repeat (4) do_update(32'h1C00_0100, 32'h1C00_0200, 1'b1, 2'b10, 1'b1);
    do_lookup(32'h1C00_0100);
    expect_resp("cnt11", 1'b1, 1'b1, 32'h1C00_0200);
    do_update(32'h1C00_0100, 32'h1C00_0200, 1'b0, 2'b10, 1'b1);
    do_lookup(32'h1C00_0100);
    expect_resp("cnt10", 1'b1, 1'b1, 32'h1C00_0200);
    do_update(32'h1C00_0100, 32'h1C00_0200, 1'b0, 2'b10, 1'b1);
    do_lookup(32'h1C00_0100);
    expect_resp("cnt01", 1'b1, 1'b0, 32'h1C00_0108);

    // Aliasing: same index, different tag
    do_lookup(32'h1C00_0300);
    expect_resp("alias_miss", 1'b0, 1'b0, 32'h1C00_0308);
    do_update(32'h1C00_0300, 32'h1C00_0400, 1'b1, 2'b10, 1'b0);
    do_lookup(32'h1C00_0300);
    expect_resp("alias_alloc", 1'b1, 1'b1, 32'h1C00_0400);
    do_lookup(32'h1C00_0100);
    expect_resp("orig_evicted", 1'b0, 1'b0, 32'h1C00_0108);

    // Not-taken miss allocates nothing; non-branch hit invalidates
    do_update(32'h1C00_0500, 32'h1C00_0900, 1'b0, 2'b10, 1'b0);
    do_lookup(32'h1C00_0500);
    expect_resp("nt_no_alloc", 1'b0, 1'b0, 32'h1C00_0508);
    do_update(32'h1C00_0300, 32'h1C00_0400, 1'b1, 2'b00, 1'b0);
    do_lookup(32'h1C00_0300);
    expect_resp("nonbranch_inval", 1'b0, 1'b0, 32'h1C00_0308);

    // Unconditional type ignores the counter
    do_update(32'h1C00_0600, 32'h1C00_0800, 1'b1, 2'b01, 1'b0);
    repeat (3) do_update(32'h1C00_0600, 32'h1C00_0800, 1'b0, 2'b01, 1'b0);
    do_lookup(32'h1C00_0600);
    expect_resp("uncond", 1'b1, 1'b1, 32'h1C00_0800);

    // Hold with if0_allowin low while the entry is updated
    do_update(32'h1C00_0100, 32'h1C00_0200, 1'b1, 2'b10, 1'b1);
    do_lookup(32'h1C00_0100);
    expect_resp("hold_pre", 1'b1, 1'b1, 32'h1C00_0200);
    if0_allowin = 1'b0; req_valid = 1'b1; fetch_pc = 32'h1C00_0300;
    upd_pc = 32'h1C00_0100; upd_tpc = 32'h1C00_0A00; upd_taken = 1'b1;
    upd_btype = 2'b10; upd_bpos = 1'b1; upd_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      upd_valid = 1'b0;
      expect_resp("hold", 1'b1, 1'b1, 32'h1C00_0200);
    end
    if0_allowin = 1'b1; req_valid = 1'b0;
    do_lookup(32'h1C00_0100);
    expect_resp("hold_post", 1'b1, 1'b1, 32'h1C00_0A00);

    // Same-cycle lookup and update: lookup sees old contents
    fetch_pc = 32'h1C00_0100; req_valid = 1'b1;
    do_update(32'h1C00_0100, 32'h1C00_0C00, 1'b1, 2'b10, 1'b0);
    req_valid = 1'b0;
    expect_resp("rbw_old", 1'b1, 1'b1, 32'h1C00_0A00);
    do_lookup(32'h1C00_0100);
    expect_resp("rbw_new", 1'b1, 1'b1, 32'h1C00_0C00);

    // Flush wins over a simultaneous update
    flush_all = 1'b1;
    upd_pc = 32'h1C00_0700; upd_tpc = 32'h1C00_0F00; upd_taken = 1'b1;
    upd_btype = 2'b10; upd_bpos = 1'b0; upd_valid = 1'b1;
    @(negedge clk);
    flush_all = 1'b0; upd_valid = 1'b0;
    count_sweep(n);
    check("flush_sweep_len", 32'(n), 32'd64);
    do_lookup(32'h1C00_0100);
    expect_resp("post_flush_a", 1'b0, 1'b0, 32'h1C00_0108);
    do_lookup(32'h1C00_0600);
    expect_resp("post_flush_b", 1'b0, 1'b0, 32'h1C00_0608);
    do_lookup(32'h1C00_0700);
    expect_resp("post_flush_c", 1'b0, 1'b0, 32'h1C00_0708);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
